// File: rtl/gf22_sram_be_banked_1w1r.sv
// Banked 1W1R memory built from single-port 2048x32-class macros with per-bit write mask.
// A one-entry posted-write buffer absorbs write/read bank-row conflicts so reads are never stalled.
module gf22_sram_be_banked_1w1r #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int BANK_ABITS = 11,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  WR_VALID,
    output logic                  WR_READY,
    input  logic [ADDR_WIDTH-1:0] WR_ADDR,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic [DATA_WIDTH-1:0] WR_MASK,
    input  logic                  RD_VALID,
    input  logic [ADDR_WIDTH-1:0] RD_ADDR,
    output logic                  RD_DVALID,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic [CNT_WIDTH-1:0]  CONFLICT_CNT
);

    localparam int RW    = ADDR_WIDTH - BANK_ABITS;
    localparam int NV    = 1 << RW;
    localparam int NH    = DATA_WIDTH / 32;
    localparam int DEPTH = 1 << BANK_ABITS;

    typedef enum logic {ST_EMPTY, ST_HELD} state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   buf_addr_reg;
    logic [DATA_WIDTH-1:0]   buf_data_reg;
    logic [DATA_WIDTH-1:0]   buf_mask_reg;
    logic [CNT_WIDTH-1:0]    cnt_reg;

    logic [RW-1:0]           wr_row, rd_row, buf_row;
    logic                    new_same_row, buf_blocked;

    logic                    issue_wr, capture, conflict_inc;
    logic [ADDR_WIDTH-1:0]   iss_addr;
    logic [DATA_WIDTH-1:0]   iss_data, iss_mask;
    logic                    mem_we, mem_re;

    logic                    rd_dvalid_reg, rd_hit_reg;
    logic [RW-1:0]           rd_row_reg;
    logic [DATA_WIDTH-1:0]   rd_bdata_reg, rd_bmask_reg, rd_hold_reg;
    logic [DATA_WIDTH-1:0]   row_q, rd_merged;
    logic                    rd_hit;

    logic [31:0]             bank_q [NV][NH];

    assign wr_row       = WR_ADDR[ADDR_WIDTH-1:BANK_ABITS];
    assign rd_row       = RD_ADDR[ADDR_WIDTH-1:BANK_ABITS];
    assign buf_row      = buf_addr_reg[ADDR_WIDTH-1:BANK_ABITS];
    assign new_same_row = RD_VALID && (wr_row == rd_row);
    assign buf_blocked  = RD_VALID && (rd_row == buf_row);

    // State register
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) state_reg <= ST_EMPTY;
        else       state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_EMPTY: if (WR_VALID && new_same_row) state_next = ST_HELD;
            ST_HELD:  if (!buf_blocked)             state_next = ST_EMPTY;
            default:  state_next = ST_EMPTY;
        endcase
    end

    // Output logic: which write (if any) reaches the macros this cycle
    always_comb begin
        WR_READY     = (state_reg == ST_EMPTY);
        issue_wr     = 1'b0;
        capture      = 1'b0;
        conflict_inc = 1'b0;
        iss_addr     = WR_ADDR;
        iss_data     = WR_DATA;
        iss_mask     = WR_MASK;
        case (state_reg)
            ST_EMPTY: begin
                if (WR_VALID) begin
                    if (new_same_row) begin
                        capture      = 1'b1;
                        conflict_inc = 1'b1;
                    end else begin
                        issue_wr = 1'b1;
                    end
                end
            end
            ST_HELD: begin
                if (buf_blocked) begin
                    conflict_inc = 1'b1;
                end else begin
                    issue_wr = 1'b1;
                    iss_addr = buf_addr_reg;
                    iss_data = buf_data_reg;
                    iss_mask = buf_mask_reg;
                end
            end
            default: ;
        endcase
    end

    // Async reset does not wait for a clock edge, so macro enables are gated directly
    assign mem_we = issue_wr && RSTN;
    assign mem_re = RD_VALID && RSTN;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            buf_addr_reg <= '0;
            buf_data_reg <= '0;
            buf_mask_reg <= '0;
        end else if (capture) begin
            buf_addr_reg <= WR_ADDR;
            buf_data_reg <= WR_DATA;
            buf_mask_reg <= WR_MASK;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN)
            cnt_reg <= '0;
        else if (conflict_inc && (cnt_reg != {CNT_WIDTH{1'b1}}))
            cnt_reg <= cnt_reg + 1'b1;
    end
    assign CONFLICT_CNT = cnt_reg;

    // Macro array: a row is never read and written in the same cycle because a
    // same-row write is always deferred into the buffer.
    for (genvar gi = 0; gi < NV; gi++) begin : g_row
        logic row_we, row_re;
        assign row_we = mem_we && (iss_addr[ADDR_WIDTH-1:BANK_ABITS] == RW'(gi));
        assign row_re = mem_re && (rd_row == RW'(gi));
        for (genvar gh = 0; gh < NH; gh++) begin : g_col
            logic [31:0]           mem [DEPTH];
            logic [31:0]           q_reg;
            logic                  ce, we;
            logic [BANK_ABITS-1:0] a;
            logic [31:0]           d, wem;
            assign ce  = row_we || row_re;
            assign we  = row_we;
            assign a   = row_we ? iss_addr[BANK_ABITS-1:0] : RD_ADDR[BANK_ABITS-1:0];
            assign d   = iss_data[gh*32 +: 32];
            assign wem = iss_mask[gh*32 +: 32];
            always_ff @(posedge CLK) begin
                if (ce) begin
                    if (we) mem[a] <= (mem[a] & ~wem) | (d & wem);
                    else    q_reg  <= mem[a];
                end
            end
            assign bank_q[gi][gh] = q_reg;
        end
    end

    // Exact-address read of a stalled buffered word must merge the pending bits
    assign rd_hit = RD_VALID && (state_reg == ST_HELD) && (RD_ADDR == buf_addr_reg);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rd_dvalid_reg <= 1'b0;
            rd_hit_reg    <= 1'b0;
            rd_row_reg    <= '0;
            rd_bdata_reg  <= '0;
            rd_bmask_reg  <= '0;
        end else begin
            rd_dvalid_reg <= RD_VALID;
            if (RD_VALID) begin
                rd_hit_reg   <= rd_hit;
                rd_row_reg   <= rd_row;
                rd_bdata_reg <= buf_data_reg;
                rd_bmask_reg <= buf_mask_reg;
            end
        end
    end

    always_comb begin
        row_q = '0;
        for (int h = 0; h < NH; h++)
            row_q[h*32 +: 32] = bank_q[rd_row_reg][h];
    end

    assign rd_merged = rd_hit_reg ? ((row_q & ~rd_bmask_reg) | (rd_bdata_reg & rd_bmask_reg)) : row_q;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN)              rd_hold_reg <= '0;
        else if (rd_dvalid_reg) rd_hold_reg <= rd_merged;
    end

    assign RD_DVALID = rd_dvalid_reg;
    assign RD_DATA   = rd_dvalid_reg ? rd_merged : rd_hold_reg;

endmodule

// File: tb/tb_gf22_sram_be_banked_1w1r.sv
// Directed + randomized bench for gf22_sram_be_banked_1w1r against an address-level memory model.
// The model applies each accepted write immediately; a read sees everything accepted before its cycle.
module tb_gf22_sram_be_banked_1w1r;

    localparam int DW = 64;
    localparam int AW = 13;
    localparam int BA = 11;
    localparam int CW = 8;

    logic          CLK;
    logic          RSTN;
    logic          WR_VALID;
    logic          WR_READY;
    logic [AW-1:0] WR_ADDR;
    logic [DW-1:0] WR_DATA;
    logic [DW-1:0] WR_MASK;
    logic          RD_VALID;
    logic [AW-1:0] RD_ADDR;
    logic          RD_DVALID;
    logic [DW-1:0] RD_DATA;
    logic [CW-1:0] CONFLICT_CNT;

    gf22_sram_be_banked_1w1r #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BANK_ABITS(BA), .CNT_WIDTH(CW)
    ) dut (
        .CLK(CLK), .RSTN(RSTN),
        .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_ADDR(WR_ADDR),
        .WR_DATA(WR_DATA), .WR_MASK(WR_MASK),
        .RD_VALID(RD_VALID), .RD_ADDR(RD_ADDR),
        .RD_DVALID(RD_DVALID), .RD_DATA(RD_DATA),
        .CONFLICT_CNT(CONFLICT_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // Reference model
    logic [DW-1:0] m_mem   [1 << AW];
    logic [DW-1:0] m_known [1 << AW];
    bit            m_held;
    int            m_prow;
    int            m_cnt;
    bit            rd_pend;
    logic [DW-1:0] rd_exp, rd_kn;

    localparam logic [DW-1:0] ONES = '1;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bump();
        if (m_cnt < (1 << CW) - 1) m_cnt++;
    endtask

    // Drive one cycle of requests (called at a falling edge), update the model,
    // then check the outputs at the next falling edge.
    task automatic step(input bit wv, input int wa, input logic [DW-1:0] wd,
                        input logic [DW-1:0] wm, input bit rv, input int ra);
        bit acc;
        int wrow, rrow;
        WR_VALID = wv;
        WR_ADDR  = AW'(wa);
        WR_DATA  = wd;
        WR_MASK  = wm;
        RD_VALID = rv;
        RD_ADDR  = AW'(ra);
        wrow = wa >> BA;
        rrow = ra >> BA;
        rd_pend = rv;
        if (rv) begin
            rd_exp = m_mem[ra];
            rd_kn  = m_known[ra];
        end
        acc = wv && !m_held;
        if (!m_held) begin
            if (acc && rv && wrow == rrow) begin
                m_held = 1'b1;
                m_prow = wrow;
                bump();
            end
        end else if (rv && rrow == m_prow) begin
            bump();
        end else begin
            m_held = 1'b0;
        end
        if (acc) begin
            m_mem[wa]   = (m_mem[wa] & ~wm) | (wd & wm);
            m_known[wa] = m_known[wa] | wm;
        end
        if (wv || rv)
            $display("[TB] t=%0t wr=%0d acc=%0d wa=%h wd=%h rd=%0d ra=%h", $time, wv, acc, wa, wd, rv, ra);
        @(negedge CLK);
        chk("rd_dvalid", DW'(RD_DVALID), DW'(rd_pend));
        if (rd_pend) chk("rd_data", RD_DATA & rd_kn, rd_exp & rd_kn);
        chk("wr_ready", DW'(WR_READY), DW'(!m_held));
        chk("conflict_cnt", DW'(CONFLICT_CNT), DW'(m_cnt));
    endtask

    task automatic idle();
        step(1'b0, 0, '0, '0, 1'b0, 0);
    endtask

    initial begin
        logic [DW-1:0] v1, v2;
        for (int i = 0; i < (1 << AW); i++) begin
            m_mem[i]   = '0;
            m_known[i] = '0;
        end
        m_held = 0; m_cnt = 0; m_prow = 0; rd_pend = 0;
        rd_exp = '0; rd_kn = '0;
        RSTN = 1'b0; WR_VALID = 0; WR_ADDR = '0; WR_DATA = '0; WR_MASK = '0;
        RD_VALID = 0; RD_ADDR = '0;
        repeat (3) @(negedge CLK);
        chk("reset_wr_ready", DW'(WR_READY), 1);
        chk("reset_rd_dvalid", DW'(RD_DVALID), 0);
        chk("reset_rd_data", RD_DATA, 0);
        chk("reset_cnt", DW'(CONFLICT_CNT), 0);
        RSTN = 1'b1;

        // Basic write then read
        step(1, 'h0005, 64'h11223344, ONES, 0, 0);
        step(0, 0, '0, '0, 1, 'h0005);
        chk("basic_rd", RD_DATA, 64'h11223344);
        chk("basic_cnt", DW'(CONFLICT_CNT), 0);
        idle();
        chk("rd_hold", RD_DATA, 64'h11223344);

        // Same-row conflict, then drain
        step(1, 'h0805, 64'hAAAAAAAA, 64'hFFFFFFFF, 1, 'h0810);
        chk("conflict_wr_ready", DW'(WR_READY), 0);
        chk("conflict_cnt1", DW'(CONFLICT_CNT), 1);
        idle();
        chk("drain_wr_ready", DW'(WR_READY), 1);
        step(0, 0, '0, '0, 1, 'h0805);
        chk("drained_rd", RD_DATA & 64'hFFFFFFFF, 64'hAAAAAAAA);

        // Masked posted write merged into a read while held
        step(1, 'h0100, 64'h12345678, ONES, 0, 0);
        step(1, 'h0100, 64'hDEADBEEF, 64'h0000FFFF, 1, 'h0200);
        step(0, 0, '0, '0, 1, 'h0100);
        chk("merge_rd", RD_DATA, 64'h1234BEEF);
        idle();
        step(0, 0, '0, '0, 1, 'h0100);
        chk("merge_after_drain", RD_DATA, 64'h1234BEEF);

        // Same-cycle write/read to one address: read-before-write
        step(1, 'h0003, '0, ONES, 0, 0);
        step(1, 'h0003, 64'hCAFEF00D, ONES, 1, 'h0003);
        chk("rbw_old", RD_DATA, 0);
        idle();
        step(0, 0, '0, '0, 1, 'h0003);
        chk("rbw_new", RD_DATA, 64'hCAFEF00D);

        // Randomized traffic over a small hot address set spanning all rows
        for (int n = 0; n < 1500; n++) begin
            int wa, ra;
            wa = (int'($urandom_range(0, 3)) << BA) | int'($urandom_range(0, 7));
            ra = (int'($urandom_range(0, 3)) << BA) | int'($urandom_range(0, 7));
            step($urandom_range(0, 9) < 6, wa, {$urandom, $urandom}, {$urandom, $urandom},
                 $urandom_range(0, 9) < 6, ra);
        end
        idle();
        idle();

        // Saturation of the conflict counter
        step(1, 'h0010, {$urandom, $urandom}, ONES, 1, 'h0020);
        for (int n = 0; n < (1 << CW) + 3; n++)
            step(0, 0, '0, '0, 1, 'h0020);
        chk("cnt_saturated", DW'(CONFLICT_CNT), DW'({CW{1'b1}}));
        idle();
        chk("cnt_after_sat", DW'(CONFLICT_CNT), DW'({CW{1'b1}}));

        // Reset while held discards the buffered write
        v1 = 64'h0123456789ABCDEF;
        v2 = 64'hFEDCBA9876543210;
        step(1, 'h0400, v1, ONES, 0, 0);
        step(1, 'h0400, v2, ONES, 1, 'h0401);
        chk("held_before_reset", DW'(WR_READY), 0);
        RSTN = 1'b0;
        #1;
        chk("rst_wr_ready", DW'(WR_READY), 1);
        chk("rst_rd_dvalid", DW'(RD_DVALID), 0);
        chk("rst_cnt", DW'(CONFLICT_CNT), 0);
        WR_VALID = 0;
        RD_VALID = 0;
        m_held = 0; m_cnt = 0; rd_pend = 0;
        for (int i = 0; i < (1 << AW); i++) m_known[i] = '0;
        @(negedge CLK);
        @(negedge CLK);
        RSTN = 1'b1;
        step(0, 0, '0, '0, 1, 'h0400);
        chk("discarded_not_seen", DW'(RD_DATA !== v2), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
